dpi_vec_unpacker: RTL and testbench
===================================

Name: dpi_vec_unpacker

Overview:
- Receive side of the word-marshalled vector path across the DPI boundary.
- The black-box wrapper passes wide arguments (e.g. the 129-bit long_in) as svBitVecVal 32-bit chunks, least-significant word first. This block rebuilds the full-width vector from that word stream inside the implementation model.
- It checks frame length and the unused pad bits in the final word, then presents the vector through a valid/ready handshake to the evaluation core.

Parameters:
- WIDTH, 129: width of the reassembled vector in bits.
- WORD_W, 32: width of one marshalled word; must match svBitVecVal chunking.
- NWORDS, ceil(WIDTH/WORD_W) = 5: derived localparam, words per frame. Not overridable.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data and in_last are valid.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  WORD_W  marshalled word, LSW first.
- in_last  input  1  marks the final word of the frame.
- out_valid  output  1  out_data holds a complete frame.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  WIDTH  reassembled vector.
- out_pad_err  output  1  pad-bit error flag for the frame on out_data; valid only while out_valid=1.
- err_len  output  1  one-cycle pulse on a frame-length violation.

Behaviour:
- Transfer rules:
  - A word transfers when in_valid && in_ready.
  - A result transfers when out_valid && out_ready.
- Reset (asynchronous, takes effect immediately):
  - state=COLLECT, word count=0, assembly register=0.
  - out_data=0, out_valid=0, out_pad_err=0, err_len=0.
  - in_ready=1 after reset deasserts.
- States:
  - COLLECT: in_ready=1. Word k (k=0..NWORDS-1) is written to assembly bits [k*WORD_W +: WORD_W], truncated at WIDTH.
  - HOLD: in_ready=0, out_valid=1.
  - DISCARD: in_ready=1. Words are dropped until the one carrying in_last.
- Completion (word NWORDS-1 accepted with in_last=1):
  - Next cycle: assembly copied to out_data, out_valid=1, state=HOLD, count=0.
  - Latency is 1 cycle from the last word's transfer to out_valid.
- Pad check:
  - When WIDTH%WORD_W != 0, any set bit in in_data[WORD_W-1:WIDTH%WORD_W] of the final word sets out_pad_err for that frame.
  - Pad bits never reach out_data.
  - When WIDTH%WORD_W == 0, out_pad_err is constant 0.
- HOLD exit:
  - On an out_valid && out_ready transfer, go to COLLECT; in_ready=1 the following cycle.
  - out_data and out_pad_err stay stable throughout HOLD regardless of out_ready.
- Short frame (in_last on word k < NWORDS-1):
  - err_len=1 for exactly the cycle after acceptance.
  - Partial frame dropped, count=0, stay in COLLECT, no out_valid.
- Long frame (word NWORDS-1 accepted with in_last=0):
  - err_len pulses once.
  - Go to DISCARD. Leave DISCARD (back to COLLECT, count=0) on acceptance of a word with in_last=1.
  - No out_valid for this frame.
- Outside HOLD:
  - out_valid=0. out_data keeps the last delivered vector.
  - out_pad_err is 0 whenever out_valid=0.
- Throughput: one frame per NWORDS+1 cycles maximum; no overlap of the HOLD state with collection.
- Reset mid-frame: the partial frame is lost, no err_len pulse, and the next frame is assembled from word 0.
- in_data and in_last are ignored when in_valid=0 or in_ready=0.

Test Plan:
1. Nominal frame:
   - Stimulus: WIDTH=129; words 0xDEADBEEF, 0x01234567, 0x89ABCDEF, 0xCAFEF00D, 0x00000001 (last), back-to-back.
   - Response: out_valid rises 1 cycle after the 5th transfer; out_data=129'h1_CAFEF00D_89ABCDEF_01234567_DEADBEEF; out_pad_err=0; err_len never asserted.
2. Pad error:
   - Stimulus: same frame with final word 0xFFFFFFFF.
   - Response: out_data[128]=1, out_pad_err=1, out_data[127:0] identical to scenario 1.
3. Short frame:
   - Stimulus: in_last on the 3rd word, then a nominal frame.
   - Response: single err_len pulse, no out_valid for the short frame; the following frame delivers scenario 1's value exactly.
4. Long frame:
   - Stimulus: 7 words, in_last only on the 7th.
   - Response: err_len pulses once, 1 cycle after the 5th word; words 6–7 are accepted (in_ready=1) and dropped; no out_valid; the next frame is correct.
5. Backpressure:
   - Stimulus: out_ready=0 for 10 cycles after out_valid, with in_valid=1 continuously.
   - Response: in_ready=0 throughout; out_data and out_pad_err stable; one cycle after out_ready=1, in_ready=1 and word 0 of the next frame is accepted.
6. Asynchronous reset:
   - Stimulus: rst pulsed mid-cycle after 3 words of a frame.
   - Response: outputs zero immediately, without waiting for a clock edge; no err_len; a subsequent full frame reassembles correctly with no stale bits from the aborted words.

Source files
------------

// File: rtl/dpi_vec_unpacker_if.sv
// Handshake bundle for the DPI word-stream unpacker: a word stream in,
// one reassembled wide vector out, plus the frame-length error pulse.
interface dpi_vec_unpacker_if #(
   parameter int WIDTH  = 129,
   parameter int WORD_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_data;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  out_data;
   logic              out_pad_err;
   logic              err_len;

   // Producer of words / consumer of vectors.
   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_pad_err, err_len
   );

   // The unpacker itself.
   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_pad_err, err_len
   );
endinterface

// File: rtl/dpi_vec_unpacker.sv
// Rebuilds a WIDTH-bit vector from 32-bit svBitVecVal words (LSW first),
// checks frame length and the unused pad bits of the final word, and
// hands the vector to the evaluation core over a valid/ready handshake.
module dpi_vec_unpacker #(
   parameter int WIDTH  = 129,
   parameter int WORD_W = 32
) (
   input logic               clk,
   input logic               rst,
   dpi_vec_unpacker_if.slave bus
);
   localparam int NWORDS = (WIDTH + WORD_W - 1) / WORD_W;
   localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam int PAD_LO = WIDTH % WORD_W;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

   typedef enum logic [1:0] {COLLECT, HOLD, DISCARD} state_t;

   state_t           state_reg,    state_next;
   logic [CNT_W-1:0] count_reg,    count_next;
   logic [WIDTH-1:0] asm_reg,      asm_next;
   logic [WIDTH-1:0] out_data_reg, out_data_next;
   logic             pad_err_reg,  pad_err_next;
   logic             err_len_reg,  err_len_next;

   logic [WIDTH-1:0] merged;
   logic             pad_bad;
   logic             accept;

   // Assembly register with the incoming word dropped into the slot
   // selected by the word count; the top slot is truncated at WIDTH so
   // pad bits never reach the vector.
   for (genvar gi = 0; gi < NWORDS; gi++) begin : g_slot
      localparam int LO = gi * WORD_W;
      localparam int SW = (WIDTH - LO < WORD_W) ? (WIDTH - LO) : WORD_W;
      assign merged[LO +: SW] = (count_reg == CNT_W'(gi)) ? bus.in_data[SW-1:0]
                                                          : asm_reg[LO +: SW];
   end

   // Pad bits exist only when the vector does not fill the last word.
   if (PAD_LO != 0) begin : g_pad
      assign pad_bad = |bus.in_data[WORD_W-1:PAD_LO];
   end else begin : g_no_pad
      assign pad_bad = 1'b0;
   end

   // No word is taken while a result is waiting, nor while reset is held.
   assign bus.in_ready    = (state_reg != HOLD) && !rst;
   assign accept          = bus.in_valid && bus.in_ready;
   assign bus.out_valid   = (state_reg == HOLD);
   assign bus.out_data    = out_data_reg;
   assign bus.out_pad_err = pad_err_reg;
   assign bus.err_len     = err_len_reg;

   // State and datapath register update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= COLLECT;
         count_reg    <= '0;
         asm_reg      <= '0;
         out_data_reg <= '0;
         pad_err_reg  <= 1'b0;
         err_len_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         count_reg    <= count_next;
         asm_reg      <= asm_next;
         out_data_reg <= out_data_next;
         pad_err_reg  <= pad_err_next;
         err_len_reg  <= err_len_next;
      end
   end

   // Frame sequencing: collect words, publish on a well-formed frame,
   // flag short/long frames and skip the tail of a long one.
   always_comb begin
      state_next    = state_reg;
      count_next    = count_reg;
      asm_next      = asm_reg;
      out_data_next = out_data_reg;
      pad_err_next  = pad_err_reg;
      err_len_next  = 1'b0;
      case (state_reg)
         COLLECT: begin
            if (accept) begin
               if (count_reg == LAST_IDX) begin
                  count_next = '0;
                  asm_next   = '0;
                  if (bus.in_last) begin
                     out_data_next = merged;
                     pad_err_next  = pad_bad;
                     state_next    = HOLD;
                  end else begin
                     err_len_next = 1'b1;
                     state_next   = DISCARD;
                  end
               end else if (bus.in_last) begin
                  // Short frame: drop what was gathered.
                  err_len_next = 1'b1;
                  count_next   = '0;
                  asm_next     = '0;
               end else begin
                  asm_next   = merged;
                  count_next = count_reg + CNT_W'(1);
               end
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               pad_err_next = 1'b0;
               state_next   = COLLECT;
            end
         end
         DISCARD: begin
            if (accept && bus.in_last) begin
               state_next = COLLECT;
            end
         end
         default: begin
            state_next = COLLECT;
         end
      endcase
   end
endmodule

// File: tb/tb_dpi_vec_unpacker.sv
// Self-checking bench for dpi_vec_unpacker: directed scenarios plus
// randomized frames compared against a whole-frame reference model.
module tb_dpi_vec_unpacker;
   localparam int W  = 129;
   localparam int WW = 32;
   localparam int NW = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dpi_vec_unpacker_if #(.WIDTH(W), .WORD_W(WW)) bus ();
   dpi_vec_unpacker #(.WIDTH(W), .WORD_W(WW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int         err_q[$];
   int         rise_q[$];
   logic [W:0] got_q[$];
   int         xfer_q[$];
   logic       prev_valid = 1'b0;

   logic [WW-1:0] nom_w[$] = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF,
                               32'hCAFEF00D, 32'h00000001};

   // Cycle counter.
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: records err_len pulses, out_valid rises and delivered frames.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.err_len) begin
            err_q.push_back(cyc);
            $display("cyc %0d err_len", cyc);
         end
         if (bus.out_valid && !prev_valid) rise_q.push_back(cyc);
         if (bus.out_valid && bus.out_ready) begin
            got_q.push_back({bus.out_pad_err, bus.out_data});
            $display("cyc %0d frame out data=%h pad_err=%b", cyc, bus.out_data, bus.out_pad_err);
         end
      end
      prev_valid <= bus.out_valid;
   end

   // Reference: a well-formed frame is the words laid end to end; anything
   // above bit W-1 is pad.
   function automatic logic [W:0] model_frame(input logic [WW-1:0] w[$]);
      logic [NW*WW-1:0] big;
      big = '0;
      foreach (w[i]) big = big | ({{(NW*WW-WW){1'b0}}, w[i]} << (WW*i));
      return {|big[NW*WW-1:W], big[W-1:0]};
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one word and hold it until it is taken (bounded).
   task automatic send_word(input logic [WW-1:0] d, input logic l, output int xc);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = l;
      xc = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            xc = cyc;
            break;
         end
      end
      if (xc < 0) begin
         checks++;
         errors++;
         $display("FAIL send_word: in_ready never rose for word %h (waited 100 cycles, required 1)", d);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      $display("cyc %0d word in data=%h last=%b", xc, d, l);
   endtask

   task automatic run_frame(input logic [WW-1:0] w[$], input int gap_max);
      int xc;
      xfer_q = {};
      foreach (w[i]) begin
         send_word(w[i], (i == w.size() - 1), xc);
         xfer_q.push_back(xc);
         if (gap_max > 0) idle($urandom_range(0, gap_max));
      end
   endtask

   task automatic wait_deliv(input int n0);
      for (int i = 0; i < 50 && got_q.size() <= n0; i++) idle(1);
   endtask

   task automatic test_reset;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b need 0", bus.out_valid); end
      checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h need 0", bus.out_data); end
      checks++; if (bus.out_pad_err !== 1'b0) begin errors++; $display("FAIL reset_pad_err: got %b need 0", bus.out_pad_err); end
      checks++; if (bus.err_len !== 1'b0) begin errors++; $display("FAIL reset_err_len: got %b need 0", bus.err_len); end
      rst = 1'b0;
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b need 1", bus.in_ready); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_nominal;
      int g0 = got_q.size(), e0 = err_q.size(), r0 = rise_q.size();
      logic [W:0] exp, g;
      int rise;
      exp = model_frame(nom_w);
      run_frame(nom_w, 0);
      wait_deliv(g0);
      g    = (got_q.size() > g0) ? got_q[g0] : 'x;
      rise = (rise_q.size() > r0) ? rise_q[r0] : -1;
      checks++; if (got_q.size() != g0 + 1) begin errors++; $display("FAIL nominal_count: got %0d frames need 1", got_q.size() - g0); end
      checks++; if (g[W-1:0] !== exp[W-1:0]) begin errors++; $display("FAIL nominal_data: got %h need %h", g[W-1:0], exp[W-1:0]); end
      checks++; if (g[W] !== 1'b0) begin errors++; $display("FAIL nominal_pad: got %b need 0", g[W]); end
      checks++; if (rise != xfer_q[NW-1] + 1) begin errors++; $display("FAIL nominal_latency: out_valid at %0d need %0d", rise, xfer_q[NW-1] + 1); end
      checks++; if (err_q.size() != e0) begin errors++; $display("FAIL nominal_err_len: got %0d pulses need 0", err_q.size() - e0); end
   endtask

   task automatic test_pad_err;
      int g0 = got_q.size(), e0 = err_q.size();
      logic [WW-1:0] w[$];
      logic [W:0] exp, nom, g;
      w = nom_w;
      w[NW-1] = 32'hFFFFFFFF;
      exp = model_frame(w);
      nom = model_frame(nom_w);
      run_frame(w, 0);
      wait_deliv(g0);
      g = (got_q.size() > g0) ? got_q[g0] : 'x;
      checks++; if (g[W-1:0] !== exp[W-1:0]) begin errors++; $display("FAIL pad_data: got %h need %h", g[W-1:0], exp[W-1:0]); end
      checks++; if (g[W] !== exp[W]) begin errors++; $display("FAIL pad_flag: got %b need %b", g[W], exp[W]); end
      checks++; if (g[W-2:0] !== nom[W-2:0]) begin errors++; $display("FAIL pad_low_bits: got %h need %h", g[W-2:0], nom[W-2:0]); end
      checks++; if (err_q.size() != e0) begin errors++; $display("FAIL pad_err_len: got %0d pulses need 0", err_q.size() - e0); end
   endtask

   task automatic test_short;
      int g0 = got_q.size(), e0 = err_q.size();
      logic [WW-1:0] w[$];
      logic [W:0] exp, g;
      int short_x, ec;
      repeat (3) w.push_back($urandom);
      run_frame(w, 0);
      short_x = xfer_q[2];
      run_frame(nom_w, 0);
      exp = model_frame(nom_w);
      wait_deliv(g0);
      g  = (got_q.size() > g0) ? got_q[g0] : 'x;
      ec = (err_q.size() > e0) ? err_q[e0] : -1;
      checks++; if (err_q.size() != e0 + 1) begin errors++; $display("FAIL short_err_count: got %0d pulses need 1", err_q.size() - e0); end
      checks++; if (ec != short_x + 1) begin errors++; $display("FAIL short_err_cycle: got %0d need %0d", ec, short_x + 1); end
      checks++; if (got_q.size() != g0 + 1) begin errors++; $display("FAIL short_frames: got %0d need 1", got_q.size() - g0); end
      checks++; if (g !== exp) begin errors++; $display("FAIL short_next_frame: got %h need %h", g, exp); end
   endtask

   task automatic test_long;
      int g0 = got_q.size(), e0 = err_q.size();
      logic [WW-1:0] w[$];
      logic [W:0] exp, g;
      int fifth_x, last_x, ec;
      repeat (7) w.push_back($urandom);
      run_frame(w, 0);
      fifth_x = xfer_q[NW-1];
      last_x  = xfer_q[6];
      idle(2);
      ec = (err_q.size() > e0) ? err_q[e0] : -1;
      checks++; if (err_q.size() != e0 + 1) begin errors++; $display("FAIL long_err_count: got %0d pulses need 1", err_q.size() - e0); end
      checks++; if (ec != fifth_x + 1) begin errors++; $display("FAIL long_err_cycle: got %0d need %0d", ec, fifth_x + 1); end
      checks++; if (last_x != fifth_x + 2) begin errors++; $display("FAIL long_tail_ready: 7th word at %0d need %0d", last_x, fifth_x + 2); end
      checks++; if (got_q.size() != g0) begin errors++; $display("FAIL long_no_frame: got %0d frames need 0", got_q.size() - g0); end
      run_frame(nom_w, 0);
      exp = model_frame(nom_w);
      wait_deliv(g0);
      g = (got_q.size() > g0) ? got_q[g0] : 'x;
      checks++; if (g !== exp) begin errors++; $display("FAIL long_next_frame: got %h need %h", g, exp); end
   endtask

   task automatic test_backpressure;
      int g0 = got_q.size();
      logic [WW-1:0] w1[$], w2[$];
      logic [W:0] exp1, exp2, g1, g2;
      int r, xc;
      repeat (NW) w1.push_back($urandom);
      repeat (NW) w2.push_back($urandom);
      w1[NW-1] = w1[NW-1] | 32'h80000000;
      exp1 = model_frame(w1);
      exp2 = model_frame(w2);
      bus.out_ready = 1'b0;
      run_frame(w1, 0);
      for (int i = 0; i < 20 && !bus.out_valid; i++) idle(1);
      bus.in_valid = 1'b1;
      bus.in_data  = w2[0];
      bus.in_last  = 1'b0;
      repeat (10) begin
         @(negedge clk);
         checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b need 0", bus.in_ready); end
         checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b need 1", bus.out_valid); end
         checks++; if (bus.out_data !== exp1[W-1:0]) begin errors++; $display("FAIL bp_data_stable: got %h need %h", bus.out_data, exp1[W-1:0]); end
         checks++; if (bus.out_pad_err !== exp1[W]) begin errors++; $display("FAIL bp_pad_stable: got %b need %b", bus.out_pad_err, exp1[W]); end
      end
      @(posedge clk);
      #1;
      r = cyc;
      bus.out_ready = 1'b1;
      send_word(w2[0], 1'b0, xc);
      checks++; if (xc != r + 1) begin errors++; $display("FAIL bp_resume: word 0 taken at %0d need %0d", xc, r + 1); end
      for (int i = 1; i < NW; i++) send_word(w2[i], (i == NW - 1), xc);
      wait_deliv(g0 + 1);
      g1 = (got_q.size() > g0) ? got_q[g0] : 'x;
      g2 = (got_q.size() > g0 + 1) ? got_q[g0 + 1] : 'x;
      checks++; if (got_q.size() != g0 + 2) begin errors++; $display("FAIL bp_count: got %0d frames need 2", got_q.size() - g0); end
      checks++; if (g1 !== exp1) begin errors++; $display("FAIL bp_frame1: got %h need %h", g1, exp1); end
      checks++; if (g2 !== exp2) begin errors++; $display("FAIL bp_frame2: got %h need %h", g2, exp2); end
   endtask

   task automatic test_async_reset;
      int g0 = got_q.size(), e0 = err_q.size();
      logic [WW-1:0] w[$], w2[$];
      logic [W:0] exp, g;
      int xc;
      repeat (NW) w.push_back($urandom);
      repeat (NW) w2.push_back($urandom & 32'h1);
      w2[0] = 32'h00000000;
      exp = model_frame(w2);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) send_word(w[i], 1'b0, xc);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %b need 0", bus.out_valid); end
      checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL arst_out_data: got %h need 0", bus.out_data); end
      checks++; if (bus.out_pad_err !== 1'b0) begin errors++; $display("FAIL arst_pad_err: got %b need 0", bus.out_pad_err); end
      checks++; if (bus.err_len !== 1'b0) begin errors++; $display("FAIL arst_err_len: got %b need 0", bus.err_len); end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle(1);
      run_frame(w2, 0);
      wait_deliv(g0);
      g = (got_q.size() > g0) ? got_q[g0] : 'x;
      checks++; if (g !== exp) begin errors++; $display("FAIL arst_next_frame: got %h need %h", g, exp); end
      checks++; if (err_q.size() != e0) begin errors++; $display("FAIL arst_err_len_count: got %0d pulses need 0", err_q.size() - e0); end
   endtask

   task automatic test_random;
      for (int f = 0; f < 40; f++) begin
         logic [WW-1:0] w[$];
         logic [W:0] exp, g;
         int len, r, g0, e0, ec, exp_ec;
         r   = $urandom_range(0, 9);
         len = (r < 6) ? NW : ((r < 8) ? $urandom_range(1, NW - 1) : $urandom_range(NW + 1, NW + 3));
         repeat (len) w.push_back($urandom);
         if (len == NW && ($urandom % 2) == 1) w[NW-1] = w[NW-1] & 32'h1;
         g0 = got_q.size();
         e0 = err_q.size();
         bus.out_ready = $urandom % 2;
         run_frame(w, 2);
         if (len == NW) begin
            exp = model_frame(w);
            for (int i = 0; i < 60 && got_q.size() == g0; i++) begin
               bus.out_ready = (i > 20) || ($urandom % 2 == 1);
               idle(1);
            end
            g = (got_q.size() > g0) ? got_q[g0] : 'x;
            checks++; if (g !== exp) begin errors++; $display("FAIL rand_frame_%0d: got %h need %h", f, g, exp); end
            checks++; if (err_q.size() != e0) begin errors++; $display("FAIL rand_err_%0d: got %0d pulses need 0", f, err_q.size() - e0); end
         end else begin
            idle(2);
            exp_ec = (len < NW) ? xfer_q[len-1] + 1 : xfer_q[NW-1] + 1;
            ec = (err_q.size() > e0) ? err_q[e0] : -1;
            checks++; if (err_q.size() != e0 + 1 || ec != exp_ec) begin errors++; $display("FAIL rand_len_err_%0d: %0d pulses first at %0d need 1 at %0d", f, err_q.size() - e0, ec, exp_ec); end
            checks++; if (got_q.size() != g0) begin errors++; $display("FAIL rand_bad_frame_%0d: got %0d frames need 0", f, got_q.size() - g0); end
         end
         bus.out_ready = 1'b1;
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_pad_err();
      test_short();
      test_long();
      test_backpressure();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
